// File: rtl/rv32_cache_pkg.sv
// rtl/rv32_cache_pkg.sv - shared sizes, refill state codes and line type for the rv32 data cache
package rv32_cache_pkg;

    localparam int LINE_BYTES = 32;
    localparam int WORDS      = LINE_BYTES / 4;
    localparam int OFFSET_W   = $clog2(LINE_BYTES);

    typedef logic [2:0] refill_state_t;

    localparam refill_state_t ST_IDLE = 3'd0;
    localparam refill_state_t ST_WB   = 3'd1;
    localparam refill_state_t ST_RD   = 3'd2;
    localparam refill_state_t ST_RESP = 3'd3;
    localparam refill_state_t ST_FILL = 3'd4;

    typedef logic [LINE_BYTES*8-1:0] line_t;

endpackage

// File: rtl/rv32_line_buf.sv
// rtl/rv32_line_buf.sv - WORDSx32 line register file: whole-line load, indexed word write, packed line read
module rv32_line_buf #(
    parameter int WORDS = 8,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WORDS*32-1:0]   load_line,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [31:0]           wdata,
    output logic [WORDS*32-1:0]   line
);
    import rv32_cache_pkg::*;

    logic [31:0] words [WORDS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) words[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < WORDS; i++) words[i] <= load_line[32*i +: 32];
        end else if (we) begin
            words[widx] <= wdata;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_line
        assign line[32*g +: 32] = words[g];
    end

endmodule

// File: rtl/rv32_cache_refill.sv
// rtl/rv32_cache_refill.sv - line refill/writeback engine; RV32_REFILL_CWF_EN enables critical-word-first reads
module rv32_cache_refill #(
    parameter int LINE_BYTES = rv32_cache_pkg::LINE_BYTES,
    parameter int WORDS      = LINE_BYTES / 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_valid,
    output logic                    miss_ready,
    input  logic [31:0]             miss_addr,
    input  logic                    victim_dirty,
    input  logic [31:0]             victim_addr,
    input  logic [LINE_BYTES*8-1:0] victim_data,
    output logic                    fill_valid,
    input  logic                    fill_ready,
    output logic [31:0]             fill_addr,
    output logic [LINE_BYTES*8-1:0] fill_data,
    output logic                    crit_valid,
    output logic [31:0]             crit_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    busy
);
    import rv32_cache_pkg::*;

    localparam int OFS_W = $clog2(LINE_BYTES);
    localparam int IDX_W = OFS_W - 2;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    refill_state_t           state;
    logic [31-OFS_W:0]       victim_tag;
    logic [IDX_W-1:0]        start_idx;
    logic [IDX_W-1:0]        first_idx;
    logic [IDX_W-1:0]        wb_cnt;
    logic [IDX_W-1:0]        wb_next;
    logic [IDX_W-1:0]        iss_cnt;
    logic [IDX_W-1:0]        iss_next;
    logic [CNT_W-1:0]        rsp_cnt;
    logic                    rsp_take;
    logic                    rsp_last;
    logic [LINE_BYTES*8-1:0] victim_line;
    logic                    unused_bits;

    assign miss_ready = (state == ST_IDLE) && !rst;
    assign busy       = (state != ST_IDLE);
    assign wb_next    = wb_cnt + 1'b1;
    assign iss_next   = iss_cnt + 1'b1;

    // Responses are only meaningful while a read burst is outstanding; anything else is dropped.
    assign rsp_take = mem_rvalid && (state == ST_RD || state == ST_RESP) && (rsp_cnt < CNT_W'(WORDS));
    assign rsp_last = rsp_take && (rsp_cnt == CNT_W'(WORDS - 1));

`ifdef RV32_REFILL_CWF_EN
    assign first_idx = miss_addr[OFS_W-1:2];
`else
    assign first_idx = '0;
`endif

    assign unused_bits = ^{miss_addr[OFS_W-1:0], victim_addr[OFS_W-1:0]};

    rv32_line_buf #(.WORDS(WORDS)) u_victim (
        .clk       (clk),
        .rst       (rst),
        .load      (miss_valid && miss_ready),
        .load_line (victim_data),
        .we        (1'b0),
        .widx      ('0),
        .wdata     (32'd0),
        .line      (victim_line)
    );

    rv32_line_buf #(.WORDS(WORDS)) u_fill (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_line ('0),
        .we        (rsp_take),
        .widx      (start_idx + rsp_cnt[IDX_W-1:0]),
        .wdata     (mem_rdata),
        .line      (fill_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            victim_tag <= '0;
            start_idx  <= '0;
            wb_cnt     <= '0;
            iss_cnt    <= '0;
            rsp_cnt    <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        fill_addr  <= {miss_addr[31:OFS_W], {OFS_W{1'b0}}};
                        victim_tag <= victim_addr[31:OFS_W];
                        start_idx  <= first_idx;
                        wb_cnt     <= '0;
                        iss_cnt    <= '0;
                        rsp_cnt    <= '0;
                        mem_valid  <= 1'b1;
                        if (victim_dirty) begin
                            state     <= ST_WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {victim_addr[31:OFS_W], {OFS_W{1'b0}}};
                            mem_wdata <= victim_data[31:0];
                        end else begin
                            state     <= ST_RD;
                            mem_we    <= 1'b0;
                            mem_addr  <= {miss_addr[31:OFS_W], first_idx, 2'b00};
                            mem_wdata <= '0;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        if (wb_cnt == LAST_IDX) begin
                            state     <= ST_RD;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                            mem_addr  <= {fill_addr[31:OFS_W], start_idx, 2'b00};
                        end else begin
                            wb_cnt    <= wb_next;
                            mem_addr  <= {victim_tag, wb_next, 2'b00};
                            mem_wdata <= victim_line[32*wb_next +: 32];
                        end
                    end
                end
                ST_RD: begin
                    if (rsp_take) rsp_cnt <= rsp_cnt + 1'b1;
                    if (mem_ready) begin
                        if (iss_cnt == LAST_IDX) begin
                            mem_valid  <= 1'b0;
                            mem_addr   <= '0;
                            state      <= rsp_last ? ST_FILL : ST_RESP;
                            fill_valid <= rsp_last;
                        end else begin
                            iss_cnt  <= iss_next;
                            mem_addr <= {fill_addr[31:OFS_W], start_idx + iss_next, 2'b00};
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_take) rsp_cnt <= rsp_cnt + 1'b1;
                    if (rsp_last) begin
                        state      <= ST_FILL;
                        fill_valid <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (fill_ready) begin
                        state      <= ST_IDLE;
                        fill_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RV32_REFILL_CWF_EN
    // The first captured word is the one the core stalled on, so forward it early.
    always_ff @(posedge clk) begin
        if (rst) begin
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= rsp_take && (rsp_cnt == '0);
            if (rsp_take && (rsp_cnt == '0)) crit_data <= mem_rdata;
        end
    end
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule

// File: doc/rv32_cache_refill.md
# rv32_cache_refill

Memory-side line refill and writeback engine for the rv32 data cache. On a cache miss it accepts one line request, writes back the dirty victim line if there is one, then issues word reads to backing memory. It assembles the returned words into a full line and hands that line back to the cache array. It sits between the cache controller and the word-wide memory port.

## Interface
Parameters:
- LINE_BYTES, 32, cache line size in bytes (power of two, ≥8)
- WORDS, LINE_BYTES/4, 32-bit words per line (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_valid  in  1  cache requests a line fill
- miss_ready  out  1  engine idle; request accepted on miss_valid&&miss_ready
- miss_addr  in  32  missing byte address
- victim_dirty  in  1  victim must be written back first (sampled at accept)
- victim_addr  in  32  victim line address (offset bits ignored)
- victim_data  in  LINE_BYTES*8  victim line; word i = bits [32*i+:32]
- fill_valid  out  1  assembled line available
- fill_ready  in  1  cache accepts line
- fill_addr  out  32  line-aligned address of fill
- fill_data  out  LINE_BYTES*8  assembled line, same packing as victim_data
- crit_valid  out  1  one-cycle critical-word pulse (see Configuration)
- crit_data  out  32  critical word
- mem_valid  out  1  memory command valid
- mem_ready  in  1  memory accepts command
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  write data
- mem_rvalid  in  1  read data valid, in command order
- mem_rdata  in  32  read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WB, RD, RESP, FILL.
- IDLE: miss_ready=1. On accept, latch the line base of miss_addr, the critical word index miss_addr[OFFSET_W-1:2], victim_dirty, victim_addr and victim_data.
  - Go to WB if victim_dirty=1, else RD.
- WB: issue WORDS write beats to victim base + 4*i, i = 0..WORDS-1 ascending.
  - A beat advances on mem_valid&&mem_ready; writes get no response.
  - After the last beat, go to RD.
- RD: issue WORDS read commands. Without the macro, order is index 0..WORDS-1.
  - Responses may arrive in the same cycles as issues. A 4-bit-wide-enough response counter counts mem_rvalid; issue and response counters are independent.
  - After the last issue, go to RESP. If the last response has already arrived, go straight to FILL.
- RESP: wait for the remaining responses. On the final one, go to FILL.
- Response k is written to the word index of the k-th issued read.
- FILL: fill_valid=1. fill_addr and fill_data are held stable until fill_valid&&fill_ready, then return to IDLE.
- mem_rvalid outside RD/RESP, or beyond WORDS responses, is ignored.
- mem_valid and all command fields are held stable while mem_ready=0.
- Reset mid-operation: abandon immediately, return to IDLE, line buffer content is don't-care. Late responses are ignored per the rule above.
- Reset values: miss_ready=0 during rst, 1 the cycle after. All other outputs are 0: fill_valid, fill_addr, fill_data, crit_valid, crit_data, mem_valid, mem_we, mem_addr, mem_wdata, busy.

## Timing
- All outputs are registered except miss_ready and busy, which decode state.
- Accept at cycle T gives the first mem_valid at T+1.
- Clean miss, with mem_ready=1 and rvalid one cycle after issue:
  - reads issued T+1..T+WORDS
  - responses T+2..T+WORDS+1
  - fill_valid at T+WORDS+2 (T+10 for 8 words)
- Dirty miss: writes T+1..T+8, reads T+9..T+16, fill_valid T+18.
- No new miss is accepted until the cycle after fill acceptance.

## Configuration
- RV32_REFILL_CWF_EN defined: critical-word-first.
  - Reads start at the critical word index and wrap modulo WORDS (e.g. index 5 of 8 gives 5,6,7,0,1,2,3,4).
  - crit_valid pulses for one cycle, the cycle after the first response is captured, with crit_data = that word.
- Not defined: reads are ascending from index 0; crit_valid and crit_data are tied to 0.
- Ports are identical in both builds.

## Structure
- rv32_cache_pkg holds:
  - LINE_BYTES default, WORDS, OFFSET_W = $clog2(LINE_BYTES)
  - the refill state enum
  - a line_t packed type
- One sub-module: rv32_line_buf, a WORDS×32 register file with an indexed word write and a packed line read. It is used for both the victim copy and fill assembly.

## Test plan
- Clean miss, miss_addr=0x0000_1234, mem_ready=1, rvalid +1, rdata=addr → reads 0x1220..0x123C; fill_valid at T+10; fill_addr=0x1220; word i = 0x1220+4i.
- Dirty miss, victim_addr=0x0000_8000, victim word i=0xA0+i → 8 writes 0x8000..0x801C with data 0xA0..0xA7 before the first read; fill_valid at T+18.
- Random mem_ready and rvalid stalls (0–5 cycles) → command fields stable while stalled; fill_data correct; exactly 8 reads issued.
- fill_ready held 0 for 4 cycles → fill_valid and fill_data stable; miss_ready=0 until the cycle after acceptance.
- With RV32_REFILL_CWF_EN, miss_addr=0x1234 → read order 0x1234,0x1238,0x123C,0x1220..0x1230; crit_valid single pulse with crit_data=0x1234; line correct.
- rst asserted after 3 read responses, then 5 stray rvalids → IDLE, all outputs at reset values, strays ignored; the next miss completes correctly.
